// File: rtl/pswd_pkg.sv
// rtl/pswd_pkg.sv - shared state encoding and widths for the password lockout path
package pswd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SESSION = 2'b01,
    ST_LOCKED  = 2'b10
  } state_t;

  localparam int FAIL_CNT_W        = 4;
  localparam int DEFAULT_MAX_FAILS = 3;

endpackage

// File: rtl/pswd_lockout_ctrl_lock_timer.sv
// rtl/pswd_lockout_ctrl_lock_timer.sv - loadable down-counter timing the lockout window
module lock_timer #(
  parameter int LOCK_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] ONE      = TW'(1);

  logic [TW-1:0] count;

  // Decrement stops at zero so the count can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pswd_lockout_ctrl.sv
// rtl/pswd_lockout_ctrl.sv - failed-attempt tracking, session state and timed lockout
module pswd_lockout_ctrl #(
  parameter int MAX_FAILS   = pswd_pkg::DEFAULT_MAX_FAILS,
  parameter int LOCK_CYCLES = 50000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           attempt_done,
  input  logic                           attempt_ok,
  input  logic                           logout,
  output logic                           entry_enable,
  output logic                           session_active,
  output logic                           lockout,
  output logic [pswd_pkg::FAIL_CNT_W-1:0] fail_count
);

  import pswd_pkg::*;

  localparam logic [FAIL_CNT_W-1:0] MAX_CNT = FAIL_CNT_W'(MAX_FAILS);
  localparam logic [FAIL_CNT_W-1:0] ONE     = FAIL_CNT_W'(1);

  state_t                  state_q, state_d;
  logic [FAIL_CNT_W-1:0]   fail_q, fail_d, fail_inc;
  logic                    timer_load;
  logic                    timer_en;
  logic                    timer_expired;

  // fail_q < MAX_FAILS whenever IDLE, so the increment cannot overflow.
  assign fail_inc = fail_q + ONE;
  assign timer_en = (state_q == ST_LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (attempt_done) begin
          if (attempt_ok) begin
            state_d = ST_SESSION;
            fail_d  = '0;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == MAX_CNT) begin
              state_d    = ST_LOCKED;
              timer_load = 1'b1;
            end
          end
        end
      end
      ST_SESSION: begin
        if (logout) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
      ST_LOCKED: begin
        if (timer_expired) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fail_d  = '0;
      end
    endcase
  end

  lock_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  assign entry_enable   = (state_q == ST_IDLE);
  assign session_active = (state_q == ST_SESSION);
  assign lockout        = (state_q == ST_LOCKED);
  assign fail_count     = fail_q;

endmodule

// File: tb/tb_pswd_lockout_ctrl.sv
// tb/tb_pswd_lockout_ctrl.sv - scoreboard bench with a behavioural lockout model
module tb_pswd_lockout_ctrl;

  localparam int MAX_FAILS   = 3;
  localparam int LOCK_CYCLES = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       attempt_done = 1'b0;
  logic       attempt_ok = 1'b0;
  logic       logout = 1'b0;
  logic       entry_enable;
  logic       session_active;
  logic       lockout;
  logic [3:0] fail_count;

  int n_cmp = 0;
  int n_err = 0;

  // Model: authorised flag, failure tally, and lockout cycles still to run.
  bit m_authed;
  int m_fails;
  int m_lock_left;

  typedef struct {
    logic [6:0] exp;
    string      tag;
  } exp_t;
  exp_t sb[$];

  pswd_lockout_ctrl #(
    .MAX_FAILS   (MAX_FAILS),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .attempt_done   (attempt_done),
    .attempt_ok     (attempt_ok),
    .logout         (logout),
    .entry_enable   (entry_enable),
    .session_active (session_active),
    .lockout        (lockout),
    .fail_count     (fail_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_out();
    logic ee, sa, lk;
    lk = (m_lock_left > 0);
    sa = m_authed;
    ee = !lk && !m_authed;
    return {ee, sa, lk, 4'(m_fails)};
  endfunction

  function automatic void model_step(bit done, bit ok, bit lo);
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_authed) begin
      if (lo) m_authed = 0;
    end else if (done) begin
      if (ok) begin
        m_authed = 1;
        m_fails  = 0;
      end else begin
        m_fails++;
        if (m_fails == MAX_FAILS) m_lock_left = LOCK_CYCLES;
      end
    end
  endfunction

  function automatic void model_reset();
    m_authed    = 0;
    m_fails     = 0;
    m_lock_left = 0;
  endfunction

  // Monitor: outputs are valid every cycle; compare one entry per clock.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = sb.pop_front();
      act = {entry_enable, session_active, lockout, fail_count};
      n_cmp++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got ee/sa/lk/cnt=%b/%b/%b/%0d required %b/%b/%b/%0d",
                 e.tag, act[6], act[5], act[4], act[3:0],
                 e.exp[6], e.exp[5], e.exp[4], e.exp[3:0]);
      end
    end
  end

  task automatic drive(input bit done, input bit ok, input bit lo, input string tag);
    exp_t e;
    @(negedge clk);
    attempt_done = done;
    attempt_ok   = ok;
    logout       = lo;
    model_step(done, ok, lo);
    e.exp = model_out();
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) drive(0, 0, 0, tag);
  endtask

  task automatic check_now(input string tag);
    logic [6:0] act, exp;
    act = {entry_enable, session_active, lockout, fail_count};
    exp = model_out();
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ee/sa/lk/cnt=%b/%b/%b/%0d required %b/%b/%b/%0d",
               tag, act[6], act[5], act[4], act[3:0], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Reset lands mid-cycle, away from any edge, and must act immediately.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #3;
    attempt_done = 0;
    attempt_ok   = 0;
    logout       = 0;
    reset        = 1;
    model_reset();
    #1;
    check_now(tag);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    model_reset();
    async_reset("reset_initial");

    drive(1, 0, 0, "two_fail_1");
    drive(1, 0, 0, "two_fail_2");
    drive(1, 1, 0, "two_fail_then_ok");
    idle_cycles(2, "session_hold");
    drive(0, 0, 1, "logout");
    idle_cycles(1, "after_logout");

    drive(1, 0, 0, "lock_fail_1");
    drive(1, 0, 0, "lock_fail_2");
    drive(1, 0, 0, "lock_enter");
    idle_cycles(2, "lock_hold");
    drive(1, 1, 0, "lock_attempt_ok");
    drive(1, 0, 0, "lock_attempt_bad");
    drive(1, 1, 1, "lock_logout");
    idle_cycles(5, "lock_release");

    drive(1, 1, 0, "enter_session");
    drive(1, 0, 1, "session_done_logout");
    idle_cycles(1, "after_coincide");

    drive(1, 0, 0, "rl_fail_1");
    drive(1, 0, 0, "rl_fail_2");
    drive(1, 0, 0, "rl_enter");
    idle_cycles(3, "rl_hold");
    async_reset("reset_mid_lockout");
    drive(1, 0, 0, "post_reset_fail");
    idle_cycles(1, "post_reset_idle");

    for (int i = 0; i < 3000; i++) begin
      bit d, o, l;
      d = ($urandom_range(99, 0) < 40);
      o = ($urandom_range(99, 0) < 30);
      l = ($urandom_range(99, 0) < 12);
      drive(d, o, l, "random");
      if (i % 700 == 699) async_reset("reset_random");
    end
    @(negedge clk);
    attempt_done = 0;
    logout       = 0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
